// File: rtl/print_arb_pkg.sv
// Shared constants for the print arbiter: FSM state encodings, the default
// end-of-message character and a log2 helper used to size FIFO pointers.
package print_arb_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Newline as emitted by the accelerator output decoder.
    localparam logic [7:0] DEFAULT_EOM_CHAR = 8'd10;

    // Ceiling log2; DEPTH is a power of two, so this is the exact index width.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        while ((32'sd1 <<< r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/print_arb_fifo.sv
// Small synchronous FIFO, one per character producer. Pointers carry one
// extra wrap bit so full and empty are told apart without a counter.
module print_arb_fifo
    import print_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty
);

    localparam int AW = clog2_f(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             wr_en_s;
    logic             rd_en_s;

    // Status flags and the accepted push/pop qualifiers; a push while full is lost.
    always_comb begin
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty   = (wr_ptr_q == rd_ptr_q);
        wr_en_s = push && !full;
        rd_en_s = pop && !empty;
        dout    = mem_q[rd_ptr_q[AW-1:0]];
    end

    // Next pointer and storage values.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_en_s ? (wr_ptr_q + (AW+1)'(1)) : wr_ptr_q;
        rd_ptr_d = rd_en_s ? (rd_ptr_q + (AW+1)'(1)) : rd_ptr_q;
        if (wr_en_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
        end else begin
            mem_d[wr_ptr_q[AW-1:0]] = mem_q[wr_ptr_q[AW-1:0]];
        end
    end

    // FIFO state registers; reset empties the FIFO and clears storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= {(AW+1){1'b0}};
            rd_ptr_q <= {(AW+1){1'b0}};
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= {WIDTH{1'b0}};
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/print_arbiter.sv
// Console print arbiter: per-producer FIFOs feeding one character sink,
// granted round-robin one whole message (terminated by EOM_CHAR) at a time.
// Optional feature: define PRINT_ARB_DROP_CNT_EN to add the drop_count port.
module print_arbiter
    import print_arb_pkg::*;
#(
    parameter int         NUM_SRC    = 2,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] EOM_CHAR   = DEFAULT_EOM_CHAR
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [8*NUM_SRC-1:0] src_char,
    input  logic [NUM_SRC-1:0]   src_valid,
    output logic [NUM_SRC-1:0]   src_pending,
    output logic [NUM_SRC-1:0]   src_overflow,
    output logic [7:0]           tx_char,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [1:0]           grant_id
`ifdef PRINT_ARB_DROP_CNT_EN
    ,
    output logic [15:0]          drop_count
`endif
);

    logic [NUM_SRC-1:0] fifo_full_s;
    logic [NUM_SRC-1:0] fifo_empty_s;
    logic [NUM_SRC-1:0] fifo_pop_s;
    logic [7:0]         fifo_dout_s [NUM_SRC];

    logic [0:0]         state_q, state_d;
    logic [1:0]         grant_q, grant_d;
    logic [1:0]         last_grant_q, last_grant_d;
    logic [NUM_SRC-1:0] overflow_q, overflow_d;
    logic [NUM_SRC-1:0] drop_s;

    logic [7:0]         head_char_s;
    logic               head_empty_s;
    logic               tx_valid_s;
    logic               transfer_s;

    logic               pick_found_s;
    logic [1:0]         pick_id_s;
    int                 best_dist_s;
    int                 rr_dist_s;
    logic               cand_s;

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_fifo
            print_arb_fifo #(
                .WIDTH (8),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (src_valid[g]),
                .din   (src_char[8*g +: 8]),
                .full  (fifo_full_s[g]),
                .pop   (fifo_pop_s[g]),
                .dout  (fifo_dout_s[g]),
                .empty (fifo_empty_s[g])
            );
        end
    endgenerate

    // Select the head of the granted FIFO; this drives the sink directly.
    always_comb begin
        head_char_s  = 8'h00;
        head_empty_s = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) begin
            head_char_s  = (grant_q == 2'(i)) ? fifo_dout_s[i]  : head_char_s;
            head_empty_s = (grant_q == 2'(i)) ? fifo_empty_s[i] : head_empty_s;
        end
    end

    // Sink handshake and the pop strobe back into the granted FIFO.
    always_comb begin
        tx_valid_s = (state_q == ST_GRANT) && !head_empty_s;
        transfer_s = tx_valid_s && tx_ready;
        tx_valid   = tx_valid_s;
        tx_char    = tx_valid_s ? head_char_s : 8'h00;
        for (int i = 0; i < NUM_SRC; i++) begin
            fifo_pop_s[i] = transfer_s && (grant_q == 2'(i));
        end
    end

    // Round-robin pick: nearest non-empty FIFO strictly after last_grant.
    always_comb begin
        pick_found_s = 1'b0;
        pick_id_s    = last_grant_q;
        best_dist_s  = NUM_SRC;
        rr_dist_s    = 0;
        cand_s       = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            rr_dist_s    = (j + 2*NUM_SRC - 1 - int'(last_grant_q)) % NUM_SRC;
            cand_s       = !fifo_empty_s[j] && (rr_dist_s < best_dist_s);
            best_dist_s  = cand_s ? rr_dist_s : best_dist_s;
            pick_id_s    = cand_s ? 2'(j) : pick_id_s;
            pick_found_s = pick_found_s | cand_s;
        end
    end

    // Message-level FSM: hold the grant until the EOM character is sent.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found_s) begin
                    grant_d = pick_id_s;
                    state_d = ST_GRANT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (transfer_s && (head_char_s == EOM_CHAR)) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Drops are pushes seen while the FIFO is full at that edge.
    always_comb begin
        drop_s     = src_valid & fifo_full_s;
        overflow_d = overflow_q | drop_s;
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 2'b00;
            last_grant_q <= 2'(NUM_SRC - 1);
            overflow_q   <= {NUM_SRC{1'b0}};
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            overflow_q   <= overflow_d;
        end
    end

    // Status outputs.
    always_comb begin
        src_pending  = ~fifo_empty_s;
        src_overflow = overflow_q;
        grant_id     = grant_q;
    end

`ifdef PRINT_ARB_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [16:0] drop_sum_s;

    // Saturating total of dropped characters; several drops in one cycle all count.
    always_comb begin
        drop_sum_s = {1'b0, drop_cnt_q};
        for (int i = 0; i < NUM_SRC; i++) begin
            drop_sum_s = drop_sum_s + {16'h0000, drop_s[i]};
        end
        drop_cnt_d = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
    end

    // Drop counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= 16'h0000;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Drop counter output.
    always_comb begin
        drop_count = drop_cnt_q;
    end
`endif

endmodule

// File: tb/tb_print_arbiter.sv
// Bench for print_arbiter: queue-based message model checked every cycle,
// plus directed scenarios with hand-computed transfer logs.
module tb_print_arbiter;

    localparam int NUM_SRC = 2;
    localparam int DEPTH   = 8;
    localparam int EOM     = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] src_char;
    logic [1:0]  src_valid;
    logic [1:0]  src_pending;
    logic [1:0]  src_overflow;
    logic [7:0]  tx_char;
    logic        tx_valid;
    logic        tx_ready;
    logic [1:0]  grant_id;
`ifdef PRINT_ARB_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    print_arbiter #(
        .NUM_SRC    (NUM_SRC),
        .FIFO_DEPTH (DEPTH),
        .EOM_CHAR   (8'd10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_char     (src_char),
        .src_valid    (src_valid),
        .src_pending  (src_pending),
        .src_overflow (src_overflow),
        .tx_char      (tx_char),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .grant_id     (grant_id)
`ifdef PRINT_ARB_DROP_CNT_EN
        ,
        .drop_count   (drop_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: pending characters per producer as plain queues.
    int  q0[$];
    int  q1[$];
    bit  m_busy;
    int  m_gid;
    int  m_last;
    int  m_ovf0, m_ovf1;
    int  m_drops;
    int  sz0, sz1, popped, nxt;
    bit  popped_eom, found;

    // Transfer log seen at the sink.
    int lg_ch[$];
    int lg_gid[$];
    int lg_cyc[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int qhead(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    // Model update at each clock edge from the inputs the DUT also sampled.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            q0.delete(); q1.delete();
            m_busy = 1'b0; m_gid = 0; m_last = NUM_SRC - 1;
            m_ovf0 = 0; m_ovf1 = 0; m_drops = 0;
        end else begin
            sz0 = q0.size(); sz1 = q1.size();
            popped_eom = 1'b0;
            if (m_busy && qsize(m_gid) > 0 && tx_ready) begin
                if (m_gid == 0) popped = q0.pop_front();
                else            popped = q1.pop_front();
                popped_eom = (popped == EOM);
            end
            if (src_valid[0]) begin
                if (sz0 >= DEPTH) begin m_ovf0 = 1; if (m_drops < 65535) m_drops++; end
                else q0.push_back(int'(src_char[7:0]));
            end
            if (src_valid[1]) begin
                if (sz1 >= DEPTH) begin m_ovf1 = 1; if (m_drops < 65535) m_drops++; end
                else q1.push_back(int'(src_char[15:8]));
            end
            if (m_busy) begin
                if (popped_eom) begin m_busy = 1'b0; m_last = m_gid; end
            end else begin
                found = 1'b0;
                for (int off = 1; off <= NUM_SRC; off++) begin
                    nxt = (m_last + off) % NUM_SRC;
                    if (!found && ((nxt == 0 && sz0 > 0) || (nxt == 1 && sz1 > 0))) begin
                        found = 1'b1; m_busy = 1'b1; m_gid = nxt;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_tx_valid", int'(tx_valid), 0);
            chk("rst_tx_char", int'(tx_char), 0);
            chk("rst_pending", int'(src_pending), 0);
        end else begin
            chk("tx_valid", int'(tx_valid), int'(m_busy && qsize(m_gid) > 0));
            if (m_busy && qsize(m_gid) > 0) begin
                chk("tx_char", int'(tx_char), qhead(m_gid));
                chk("grant_id", int'(grant_id), m_gid);
            end
            chk("pending", int'(src_pending), (q1.size() > 0 ? 2 : 0) + (q0.size() > 0 ? 1 : 0));
            chk("overflow", int'(src_overflow), m_ovf1 * 2 + m_ovf0);
`ifdef PRINT_ARB_DROP_CNT_EN
            chk("drop_count", int'(drop_count), m_drops);
`endif
            if (tx_valid && tx_ready) begin
                lg_ch.push_back(int'(tx_char));
                lg_gid.push_back(int'(grant_id));
                lg_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int i, input int ch);
        src_valid[i] = 1'b1;
        src_char[8*i +: 8] = ch[7:0];
        tick();
        src_valid = 2'b00;
    endtask

    task automatic push2(input int ch);
        src_valid = 2'b11;
        src_char  = {ch[7:0], ch[7:0]};
        tick();
        src_valid = 2'b00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic clear_log();
        lg_ch.delete(); lg_gid.delete(); lg_cyc.delete();
    endtask

    task automatic wait_log(input int n, input string name);
        int k;
        k = 0;
        while (lg_ch.size() < n && k < 100) begin
            tick();
            k++;
        end
        chk(name, lg_ch.size(), n);
        tick();
    endtask

    task automatic chk_log(input string name, input int idx, input int ch, input int gid);
        if (idx < lg_ch.size()) begin
            chk({name, "_char"}, lg_ch[idx], ch);
            chk({name, "_gid"}, lg_gid[idx], gid);
        end else begin
            chk({name, "_present"}, idx, lg_ch.size() - 1);
        end
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    int t0;

    initial begin
        rst = 1'b1; src_valid = 2'b00; src_char = 16'h0000; tx_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset_tx_valid", int'(tx_valid), 0);
        chk("reset_grant_id", int'(grant_id), 0);
        chk("reset_overflow", int'(src_overflow), 0);

        // 1: single message, one char per cycle, first valid one cycle after first push.
        tx_ready = 1'b1; clear_log();
        push(0, 1); t0 = cyc;
        push(0, 2); push(0, 3); push(0, 4); push(0, 10);
        wait_log(5, "t1_count");
        chk_log("t1_c0", 0, 1, 0); chk_log("t1_c1", 1, 2, 0); chk_log("t1_c2", 2, 3, 0);
        chk_log("t1_c3", 3, 4, 0); chk_log("t1_c4", 4, 10, 0);
        for (int k = 0; k < 5 && k < lg_cyc.size(); k++) chk("t1_timing", lg_cyc[k], t0 + 1 + k);
        tick();
        chk("t1_idle", int'(tx_valid), 0);

        // 2: two producers, same cycles; whole messages, one idle cycle between.
        do_reset(); tx_ready = 1'b1; clear_log();
        push2(5); push2(10);
        wait_log(4, "t2_count");
        chk_log("t2_a", 0, 5, 0); chk_log("t2_b", 1, 10, 0);
        chk_log("t2_c", 2, 5, 1); chk_log("t2_d", 3, 10, 1);
        if (lg_cyc.size() >= 3) chk("t2_gap", lg_cyc[2] - lg_cyc[1], 2);

        // 3: granted producer stalls mid-message; no interleave from the other.
        do_reset(); tx_ready = 1'b1; clear_log();
        push(1, 7); push(0, 3); push(0, 10);
        repeat (4) tick();
        chk("t3_stall_valid", int'(tx_valid), 0);
        chk("t3_stall_grant", int'(grant_id), 1);
        chk("t3_stall_pending", int'(src_pending), 1);
        push(1, 10);
        wait_log(4, "t3_count");
        chk_log("t3_a", 0, 7, 1); chk_log("t3_b", 1, 10, 1);
        chk_log("t3_c", 2, 3, 0); chk_log("t3_d", 3, 10, 0);

        // 4: sink back-pressure for five cycles mid-message.
        do_reset(); tx_ready = 1'b1; clear_log();
        push(0, 1); push(0, 2); push(0, 3);
        tx_ready = 1'b0;
        push(0, 10);
        chk("t4_hold_valid", int'(tx_valid), 1);
        chk("t4_hold_char", int'(tx_char), 2);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t4_hold_valid", int'(tx_valid), 1);
            chk("t4_hold_char", int'(tx_char), 2);
        end
        tx_ready = 1'b1;
        wait_log(4, "t4_count");
        chk_log("t4_a", 0, 1, 0); chk_log("t4_b", 1, 2, 0);
        chk_log("t4_c", 2, 3, 0); chk_log("t4_d", 3, 10, 0);

        // 5: overflow with a blocked sink; a push into a full FIFO is lost even with a pop.
        do_reset(); tx_ready = 1'b0; clear_log();
        for (int k = 0; k < 10; k++) push(0, 8'h41 + k);
        chk("t5_overflow", int'(src_overflow), 1);
        chk("t5_pending", int'(src_pending), 1);
`ifdef PRINT_ARB_DROP_CNT_EN
        chk("t5_drop_count", int'(drop_count), 2);
`endif
        tx_ready = 1'b1;
        push(0, 8'h4B);
`ifdef PRINT_ARB_DROP_CNT_EN
        chk("t5_drop_same_cycle", int'(drop_count), 3);
`endif
        wait_log(8, "t5_drain");
        push(0, 10);
        wait_log(9, "t5_count");
        for (int k = 0; k < 8; k++) chk_log("t5_data", k, 8'h41 + k, 0);
        chk_log("t5_eom", 8, 10, 0);
        chk("t5_overflow_sticky", int'(src_overflow), 1);

        // 6: reset mid-message discards everything; src0 granted first after release.
        tx_ready = 1'b0;
        push(0, 1); push(0, 2); push(1, 9);
        chk("t6_pre_valid", int'(tx_valid), 1);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", int'(tx_valid), 0);
        chk("t6_rst_char", int'(tx_char), 0);
        chk("t6_rst_pending", int'(src_pending), 0);
        chk("t6_rst_overflow", int'(src_overflow), 0);
`ifdef PRINT_ARB_DROP_CNT_EN
        chk("t6_rst_drop", int'(drop_count), 0);
`endif
        tick();
        rst = 1'b0;
        tx_ready = 1'b1; clear_log();
        push2(8); push2(10);
        wait_log(4, "t6_count");
        chk_log("t6_a", 0, 8, 0); chk_log("t6_b", 1, 10, 0);
        chk_log("t6_c", 2, 8, 1); chk_log("t6_d", 3, 10, 1);

        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
